mul_ctrl: RTL and testbench
===========================

MUL_CTRL -- requirements
Module: mul_ctrl

Interface
REQ-001 No parameters; datapath width fixed at 32 bits.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 start  in  1  request to begin a multiply; sampled only in IDLE.
REQ-005 a  in  32  multiplicand, captured on accepted start.
REQ-006 b  in  32  multiplier, captured on accepted start.
REQ-007 busy  out  1  high in every state except IDLE and DONE.
REQ-008 done  out  1  one-cycle pulse, high only in DONE.
REQ-009 product  out  64  registered result; holds until next completion.

Function
REQ-010 Shall compute a*b by 32-step shift-add, using one instance of the team's 32-bit ALU for every addition or negation.
REQ-011 States IDLE, RUN, DONE (plus NEGA, NEGB, NEGLO, NEGHI when MUL_SIGNED_EN is defined).
REQ-012 IDLE with start=1: load mcand<=a, hi<=0, lo<=b, cnt<=0, go to RUN; start=0: remain IDLE.
REQ-013 RUN step: if lo[0]=1, ALU op=ADD, binvert=0, cin=0, in1=hi, in2=mcand; {hi,lo}<={cout,sum,lo[31:1]}; else {hi,lo}<={1'b0,hi,lo[31:1]}.
REQ-014 cnt shall be 5 bits; RUN with cnt=31 performs the final step, writes product<={hi,lo} (post-step value) and goes to DONE.
REQ-015 DONE shall last exactly one cycle, then go to IDLE; start during DONE is ignored.
REQ-016 Latency: start sampled at edge N -> done high in the cycle after edge N+32 (unsigned).
REQ-017 start in any state other than IDLE shall be ignored; a and b need not be held after acceptance.
REQ-018 ALU op/binvert/cin shall be driven to ADD/0/0 in states where the ALU result is unused.
REQ-019 Carry-out of each add is the 33rd bit of the shifted sum; no overflow is possible and none is reported.

Reset
REQ-020 reset=1 at an edge: state<=IDLE, cnt, mcand, hi, lo, product<=0; busy=0, done=0 next cycle.
REQ-021 reset has priority over start and aborts any in-flight operation; no done pulse follows.

Configuration
REQ-022 Macro MUL_SIGNED_EN: when defined, a and b are two's-complement signed; when undefined, unsigned, with no NEG states.
REQ-023 Signed path: IDLE->NEGA->NEGB->RUN->(cnt=31)->NEGLO->NEGHI->DONE; every state always traversed, giving fixed latency of 36 edges.
REQ-024 NEGA/NEGB: if operand bit31=1, replace with 0-x (ALU in1=0, in2=x, binvert=1, cin=1, op=ADD); else unchanged. Sign s=a[31]^b[31] latched at start.
REQ-025 NEGLO/NEGHI: if s=1, negate {hi,lo} as 64 bits: lo via ALU 0-lo with cin=1, borrow carried as cin of 0-hi step; product written at NEGHI.
REQ-026 Operand 0x80000000 negates to itself and shall be treated as unsigned magnitude 2^31.

Structure
REQ-027 Shared package: ALU op constants (AND=2'b00, OR=2'b01, ADD=2'b10) and state encoding constants.
REQ-028 One sub-module: the team's 32-bit ALU (alu), instantiated once; no other arithmetic operators in mul_ctrl.

Verification
REQ-029 a=3, b=5, start one cycle -> product=0x000000000000000F, done after 33 cycles (unsigned build).
REQ-030 a=b=0xFFFFFFFF -> product=0xFFFFFFFE00000001 (unsigned build).
REQ-031 start pulsed at cnt=10 with a=7 -> ignored; original result completes unchanged.
REQ-032 reset at cnt=10 -> next cycle busy=0, done=0, product=0; no done pulse for 40 cycles.
REQ-033 Signed build: a=0xFFFFFFFD (-3), b=5 -> product=0xFFFFFFFFFFFFFFF1 at 37th cycle; a=0x80000000, b=0xFFFFFFFF -> 0x0000000080000000.
REQ-034 Back-to-back: start asserted in the IDLE cycle right after done -> accepted, second result correct.

Source files
------------

// File: rtl/mul_ctrl_pkg.sv
// mul_ctrl_pkg: ALU op codes, FSM state encoding and a bitwise counter increment.
// NEG states exist only when MUL_SIGNED_EN is defined.
package mul_ctrl_pkg;
  localparam logic [1:0] ALU_AND = 2'b00;
  localparam logic [1:0] ALU_OR  = 2'b01;
  localparam logic [1:0] ALU_ADD = 2'b10;
`ifdef MUL_SIGNED_EN
  typedef enum logic [2:0] {S_IDLE, S_RUN, S_DONE, S_NEGA, S_NEGB, S_NEGLO, S_NEGHI} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
`endif
  // Ripple increment from gates so the controller needs no arithmetic operator.
  function automatic logic [4:0] inc5(input logic [4:0] x);
    logic [4:0] r;
    logic c;
    c = 1'b1;
    for (int i = 0; i < 5; i++) begin
      r[i] = x[i] ^ c;
      c = c & x[i];
    end
    return r;
  endfunction
endpackage

// File: rtl/mul_ctrl_alu.sv
// alu: 32-bit AND/OR/ADD unit with operand-b inversion and carry-in/out.
module alu
  import mul_ctrl_pkg::*;
(
  input  logic [1:0]  op,
  input  logic        binvert,
  input  logic        cin,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  output logic [31:0] result,
  output logic        cout
);
  logic [31:0] bb;
  logic [32:0] sum;
  assign bb = binvert ? ~in2 : in2;
  assign sum = {1'b0, in1} + {1'b0, bb} + {32'd0, cin};
  assign result = op == ALU_AND ? in1 & bb : op == ALU_OR ? in1 | bb : sum[31:0];
  assign cout = sum[32];
endmodule

// File: rtl/mul_ctrl.sv
// mul_ctrl: 32x32->64 shift-add multiplier sequenced over one shared ALU.
// Define MUL_SIGNED_EN for two's-complement operands (adds NEG states, fixed 36-edge latency).
module mul_ctrl
  import mul_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [63:0] product
);
  state_t state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic [31:0] mcand_q, mcand_d, hi_q, hi_d, lo_q, lo_d;
  logic [63:0] product_q, product_d;
`ifdef MUL_SIGNED_EN
  logic s_q, s_d, c_q, c_d;
`endif
  logic [1:0] alu_op;
  logic alu_binv, alu_cin, alu_cout;
  logic [31:0] alu_in1, alu_in2, alu_res, step_hi;
  alu u_alu (
    .op(alu_op), .binvert(alu_binv), .cin(alu_cin), .in1(alu_in1), .in2(alu_in2),
    .result(alu_res), .cout(alu_cout)
  );
  assign step_hi = lo_q[0] ? alu_res : hi_q;
  assign busy = state_q != S_IDLE && state_q != S_DONE;
  assign done = state_q == S_DONE;
  assign product = product_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    mcand_d = mcand_q;
    hi_d = hi_q;
    lo_d = lo_q;
    product_d = product_q;
`ifdef MUL_SIGNED_EN
    s_d = s_q;
    c_d = c_q;
`endif
    alu_op = ALU_ADD;
    alu_binv = 1'b0;
    alu_cin = 1'b0;
    alu_in1 = hi_q;
    alu_in2 = mcand_q;
    case (state_q)
      S_IDLE: if (start) begin
        mcand_d = a;
        hi_d = '0;
        lo_d = b;
        cnt_d = '0;
`ifdef MUL_SIGNED_EN
        s_d = a[31] ^ b[31];
        state_d = S_NEGA;
`else
        state_d = S_RUN;
`endif
      end
      S_RUN: begin
        hi_d = {lo_q[0] & alu_cout, step_hi[31:1]};
        lo_d = {step_hi[0], lo_q[31:1]};
        cnt_d = inc5(cnt_q);
`ifdef MUL_SIGNED_EN
        if (cnt_q == 5'd31) state_d = S_NEGLO;
`else
        if (cnt_q == 5'd31) begin
          product_d = {hi_d, lo_d};
          state_d = S_DONE;
        end
`endif
      end
`ifdef MUL_SIGNED_EN
      S_NEGA: begin
        alu_in1 = '0;
        alu_binv = 1'b1;
        alu_cin = 1'b1;
        if (mcand_q[31]) mcand_d = alu_res;
        state_d = S_NEGB;
      end
      S_NEGB: begin
        alu_in1 = '0;
        alu_in2 = lo_q;
        alu_binv = 1'b1;
        alu_cin = 1'b1;
        if (lo_q[31]) lo_d = alu_res;
        state_d = S_RUN;
      end
      // 64-bit negate: low word carry feeds the high word step
      S_NEGLO: begin
        alu_in1 = '0;
        alu_in2 = lo_q;
        alu_binv = 1'b1;
        alu_cin = 1'b1;
        if (s_q) lo_d = alu_res;
        c_d = alu_cout;
        state_d = S_NEGHI;
      end
      S_NEGHI: begin
        alu_in1 = '0;
        alu_in2 = hi_q;
        alu_binv = 1'b1;
        alu_cin = c_q;
        if (s_q) hi_d = alu_res;
        product_d = {hi_d, lo_q};
        state_d = S_DONE;
      end
`endif
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      mcand_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
      product_q <= '0;
`ifdef MUL_SIGNED_EN
      s_q <= 1'b0;
      c_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      mcand_q <= mcand_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      product_q <= product_d;
`ifdef MUL_SIGNED_EN
      s_q <= s_d;
      c_q <= c_d;
`endif
    end
  end
endmodule

// File: tb/tb_mul_ctrl.sv
// tb_mul_ctrl: scoreboard bench for mul_ctrl; expectations follow MUL_SIGNED_EN.
module tb_mul_ctrl;
  logic clk = 1'b0;
  logic reset, start, busy, done;
  logic [31:0] a, b;
  logic [63:0] product;
  logic [63:0] exp_q[$];
  int passed = 0, total = 0;
`ifdef MUL_SIGNED_EN
  localparam int LAT = 37;
`else
  localparam int LAT = 33;
`endif
  mul_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .product(product)
  );
  always #5 clk = ~clk;
  function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y);
`ifdef MUL_SIGNED_EN
    logic [63:0] xe, ye;
    xe = {{32{x[31]}}, x};
    ye = {{32{y[31]}}, y};
    return xe * ye;
`else
    return {32'd0, x} * {32'd0, y};
`endif
  endfunction
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic launch(input logic [31:0] x, input logic [31:0] y);
    a = x;
    b = y;
    start = 1'b1;
    exp_q.push_back(model(x, y));
    step;
    start = 1'b0;
    a = $urandom;
    b = $urandom;
  endtask
  task automatic wait_done(output int n);
    n = 1;
    while (done !== 1'b1 && n < 200) begin
      step;
      n++;
    end
  endtask
  task automatic test_reset;
    reset = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (2) step;
    reset = 1'b0;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
    total++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else passed++;
    total++; if (product !== 64'd0) $display("FAIL reset_product got %h want 0", product); else passed++;
    repeat (3) step;
    total++; if (busy !== 1'b0) $display("FAIL idle_busy got %b want 0", busy); else passed++;
  endtask
  task automatic test_basic;
    int n;
    logic [63:0] e;
    launch(32'd3, 32'd5);
    total++; if (busy !== 1'b1) $display("FAIL basic_busy got %b want 1", busy); else passed++;
    wait_done(n);
    total++; if (n !== LAT) $display("FAIL basic_latency got %0d want %0d", n, LAT); else passed++;
    e = exp_q.pop_front();
    total++; if (product !== e) $display("FAIL basic_product got %h want %h", product, e); else passed++;
    total++; if (product !== 64'hF) $display("FAIL basic_const got %h want f", product); else passed++;
    step;
    total++; if (done !== 1'b0) $display("FAIL done_pulse got %b want 0", done); else passed++;
    total++; if (product !== 64'hF) $display("FAIL product_hold got %h want f", product); else passed++;
  endtask
  task automatic test_patterns;
    logic [31:0] pa [8] = '{32'hFFFFFFFF, 32'h0, 32'h1, 32'h80000000, 32'hFFFFFFFD, 32'h7FFFFFFF, 32'h12345678, 32'hA5A5A5A5};
    logic [31:0] pb [8] = '{32'hFFFFFFFF, 32'hDEADBEEF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h5, 32'h80000000, 32'h9ABCDEF0, 32'h5A5A5A5A};
    int n;
    logic [63:0] e;
    for (int i = 0; i < 10; i++) begin
      if (i < 8) launch(pa[i], pb[i]);
      else launch($urandom, $urandom);
      wait_done(n);
      total++; if (n !== LAT) $display("FAIL pat%0d_latency got %0d want %0d", i, n, LAT); else passed++;
      e = exp_q.pop_front();
      total++; if (product !== e) $display("FAIL pat%0d_product got %h want %h", i, product, e); else passed++;
`ifdef MUL_SIGNED_EN
      if (i == 3) begin
        total++; if (product !== 64'h0000000080000000) $display("FAIL min_neg got %h want 0000000080000000", product); else passed++;
      end
      if (i == 4) begin
        total++; if (product !== 64'hFFFFFFFFFFFFFFF1) $display("FAIL neg3x5 got %h want fffffffffffffff1", product); else passed++;
      end
`else
      if (i == 0) begin
        total++; if (product !== 64'hFFFFFFFE00000001) $display("FAIL max_sq got %h want fffffffe00000001", product); else passed++;
      end
`endif
      step;
    end
  endtask
  task automatic test_ignore_start;
    int n;
    logic [63:0] e;
    launch(32'h00012345, 32'h00000777);
    repeat (10) step;
    a = 32'd7;
    b = 32'd9;
    start = 1'b1;
    step;
    start = 1'b0;
    total++; if (busy !== 1'b1) $display("FAIL ignore_busy got %b want 1", busy); else passed++;
    wait_done(n);
    total++; if (n + 11 !== LAT) $display("FAIL ignore_latency got %0d want %0d", n + 11, LAT); else passed++;
    e = exp_q.pop_front();
    total++; if (product !== e) $display("FAIL ignore_product got %h want %h", product, e); else passed++;
    step;
  endtask
  task automatic test_reset_abort;
    int seen;
    launch(32'd9, 32'd9);
    void'(exp_q.pop_back());
    repeat (10) step;
    reset = 1'b1;
    step;
    reset = 1'b0;
    total++; if (busy !== 1'b0) $display("FAIL abort_busy got %b want 0", busy); else passed++;
    total++; if (done !== 1'b0) $display("FAIL abort_done got %b want 0", done); else passed++;
    total++; if (product !== 64'd0) $display("FAIL abort_product got %h want 0", product); else passed++;
    seen = 0;
    repeat (40) begin
      if (done === 1'b1) seen++;
      step;
    end
    total++; if (seen !== 0) $display("FAIL abort_no_done got %0d pulses want 0", seen); else passed++;
  endtask
  task automatic test_back_to_back;
    int n;
    logic [63:0] e;
    launch(32'hDEADBEEF, 32'h12345678);
    wait_done(n);
    total++; if (n !== LAT) $display("FAIL b2b_first_latency got %0d want %0d", n, LAT); else passed++;
    e = exp_q.pop_front();
    total++; if (product !== e) $display("FAIL b2b_first_product got %h want %h", product, e); else passed++;
    a = 32'd5;
    b = 32'd6;
    start = 1'b1;
    step;
    total++; if (busy !== 1'b0) $display("FAIL b2b_done_ignored busy got %b want 0", busy); else passed++;
    total++; if (done !== 1'b0) $display("FAIL b2b_idle_done got %b want 0", done); else passed++;
    exp_q.push_back(model(32'd5, 32'd6));
    step;
    start = 1'b0;
    wait_done(n);
    total++; if (n !== LAT) $display("FAIL b2b_second_latency got %0d want %0d", n, LAT); else passed++;
    e = exp_q.pop_front();
    total++; if (product !== e) $display("FAIL b2b_second_product got %h want %h", product, e); else passed++;
    step;
  endtask
  initial begin
    reset = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    test_reset;
    test_basic;
    test_patterns;
    test_ignore_start;
    test_reset_abort;
    test_back_to_back;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
